// File: rtl/dff_bank_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// dff_arb_pkg
// Shared types and defaults for the dff_bank_arbiter slice.
//   state_t  : arbiter FSM states (IDLE, OWNED)
//   DEF_*    : default parameter values for NREQ / WIDTH / MAX_HOLD
//   onehot() : one-hot vector of a requester index, for up to MAX_NREQ requesters
// ----------------------------------------------------------------------------
package dff_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_HOLD = 4;

  // Upper bound on the requester count; onehot() is sized to it.
  localparam int MAX_NREQ = 8;

  // Bit idx set when idx < n, all zero otherwise.
  function automatic logic [MAX_NREQ-1:0] onehot(input int idx, input int n);
    logic [MAX_NREQ-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (i == idx && i < n) begin
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// ----------------------------------------------------------------------------
// dff_bank_arbiter_if
// Bundles the requester-facing and storage-facing signals of the arbiter.
//   req   [NREQ]        per-requester request level
//   wdata [NREQ*WIDTH]  packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt   [NREQ]        registered one-hot grant
//   Q, Qb [WIDTH]       shared bank contents and its complement
//   busy                high while a requester owns the bank
//   owner [clog2(NREQ)] current owner index, meaningful only when busy
// Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface dff_bank_arbiter_if
  import dff_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
);

  logic [NREQ-1:0]         req;
  logic [NREQ*WIDTH-1:0]   wdata;
  logic [NREQ-1:0]         gnt;
  logic [WIDTH-1:0]        Q;
  logic [WIDTH-1:0]        Qb;
  logic                    busy;
  logic [$clog2(NREQ)-1:0] owner;

  modport master (
    output req, wdata,
    input  gnt, Q, Qb, busy, owner
  );

  modport slave (
    input  req, wdata,
    output gnt, Q, Qb, busy, owner
  );

endinterface

// File: rtl/dff_bank_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational rotating priority picker: returns the first set req bit found
// scanning upward from ptr with wrap-around.
//   req   [NREQ]          request vector
//   ptr   [clog2(NREQ)]   starting scan position
//   found                 at least one req bit set
//   idx   [clog2(NREQ)]   winning index (0 when nothing found)
// ----------------------------------------------------------------------------
module rr_pick
  import dff_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IDXW = $clog2(NREQ);
  localparam int SW   = IDXW + 1;

  // slot[gi] is the requester examined at scan offset gi; rot[gi] its request.
  logic [IDXW-1:0] slot [NREQ];
  logic [NREQ-1:0] rot;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rot
      logic [SW-1:0] sum_w;
      // One extra bit so ptr+offset never overflows before the modulo fold.
      assign sum_w     = {1'b0, ptr} + SW'(gi);
      assign slot[gi]  = (sum_w >= SW'(NREQ)) ? IDXW'(sum_w - SW'(NREQ)) : IDXW'(sum_w);
      assign rot[gi]   = req[slot[gi]];
    end
  endgenerate

  // Scan from the far end so the smallest offset is the last to write idx.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        idx   = slot[k];
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// ----------------------------------------------------------------------------
// dff_bank_arbiter
// Shares one WIDTH-bit register bank between NREQ requesters. The winner of a
// round-robin pick owns the bank and writes its wdata word every cycle until it
// drops req or has held the grant for MAX_HOLD cycles; every release is
// followed by exactly one idle cycle before the next grant.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   dff_bank_arbiter_if.slave (req, wdata in; gnt, Q, Qb, busy, owner out)
// Build option DFF_ARB_FIXED_PRIORITY_EN selects lowest-index priority and
// removes the rotating pointer register.
// ----------------------------------------------------------------------------
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic               clk,
  input  logic               rst,
  dff_bank_arbiter_if.slave  bus
);

  localparam int IDXW = $clog2(NREQ);
  localparam int HW   = $clog2(MAX_HOLD + 1);

  state_t            state_reg;
  logic [NREQ-1:0]   gnt_reg;
  logic [WIDTH-1:0]  q_reg;
  logic              busy_reg;
  logic [IDXW-1:0]   owner_reg;
  logic [HW-1:0]     hold_cnt_reg;

  logic [WIDTH-1:0]  wdata_words [NREQ];
  logic [IDXW-1:0]   pick_ptr;
  logic              pick_found;
  logic [IDXW-1:0]   pick_idx;
  logic [NREQ-1:0]   pick_gnt;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_words
      assign wdata_words[gi] = bus.wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

`ifdef DFF_ARB_FIXED_PRIORITY_EN
  // Scanning from 0 turns the rotating picker into a lowest-index encoder.
  assign pick_ptr = '0;
`else
  logic [IDXW-1:0]   rr_ptr_reg;
  assign pick_ptr = rr_ptr_reg;
`endif

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (bus.req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign pick_gnt = NREQ'(onehot(int'(pick_idx), NREQ));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      q_reg        <= '0;
      busy_reg     <= 1'b0;
      owner_reg    <= '0;
      hold_cnt_reg <= '0;
`ifndef DFF_ARB_FIXED_PRIORITY_EN
      rr_ptr_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            // Grant and first write land on the same edge.
            state_reg    <= OWNED;
            gnt_reg      <= pick_gnt;
            q_reg        <= wdata_words[pick_idx];
            busy_reg     <= 1'b1;
            owner_reg    <= pick_idx;
            hold_cnt_reg <= HW'(1);
          end
        end
        OWNED: begin
          if (bus.req[owner_reg] && (hold_cnt_reg < HW'(MAX_HOLD))) begin
            q_reg        <= wdata_words[owner_reg];
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end else begin
            // Release; Q keeps the last written word, owner keeps its value
            // but is no longer meaningful once busy drops.
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            busy_reg     <= 1'b0;
            hold_cnt_reg <= '0;
`ifndef DFF_ARB_FIXED_PRIORITY_EN
            rr_ptr_reg   <= (owner_reg == IDXW'(NREQ - 1)) ? '0 : owner_reg + 1'b1;
`endif
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt   = gnt_reg;
  assign bus.Q     = q_reg;
  assign bus.Qb    = ~q_reg;
  assign bus.busy  = busy_reg;
  assign bus.owner = owner_reg;

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Shares one WIDTH-bit bank of D flip-flops (outputs Q/Qb) between NREQ requesters.
- Round-robin grant with bounded hold: the granted owner writes its data into the bank every cycle until it releases or its hold budget expires.
- Sits between requester logic and the shared storage register, and sequences all writes to it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, storage/data width.
- MAX_HOLD, 4, maximum consecutive cycles one owner may keep the grant (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request level.
- wdata  input  NREQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  registered one-hot grant (all zero when idle).
- Q  output  WIDTH  shared bank contents.
- Qb  output  WIDTH  bitwise complement of Q, always.
- busy  output  1  high while in OWNED.
- owner  output  $clog2(NREQ)  index of current owner; valid only when busy.

Behaviour:
- Reset (async, immediate): state=IDLE, gnt=0, Q=0, Qb=all ones, busy=0, owner=0, rr_ptr=0, hold_cnt=0.
- State IDLE:
  - If any req bit is set, pick winner w = first set req bit scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
  - Same clock edge: gnt=onehot(w), owner=w, Q<=wdata[w], hold_cnt=1, state->OWNED.
  - If no req bit is set: remain in IDLE with all outputs held.
- State OWNED, each edge:
  - If req[owner]=1 and hold_cnt<MAX_HOLD: Q<=wdata[owner], hold_cnt++, stay in OWNED.
  - Else (owner dropped req, or budget hit): release. gnt=0, Q holds its value, rr_ptr=(owner+1) mod NREQ, hold_cnt=0, state->IDLE.
- Latency:
  - Req to grant and first write: 1 edge.
  - Release always inserts exactly one IDLE bubble cycle before the next grant (a re-grant to the same requester is included).
- Q changes only on edges where gnt is asserted after that edge; Q never changes while idle.
- Requests from non-owners during OWNED are ignored (no preemption).
- Inputs are sampled only at edges; req glitches between edges have no effect.
- MAX_HOLD=1 gives exactly one write per grant, then a bubble.
- Reset asserted mid-ownership: immediate return to reset values; the in-flight write is lost.
- Wrap: rr_ptr = NREQ-1 followed by a release gives rr_ptr = 0.

Optional Feature:
- Macro: DFF_ARB_FIXED_PRIORITY_EN.
- Defined: the winner is the lowest-index set req bit; rr_ptr is neither kept nor updated. Hold budget and bubble rules are unchanged.
- Undefined: round-robin as specified above.

Decomposition:
- Package dff_arb_pkg:
  - state enum {IDLE, OWNED}.
  - Localparam default values.
  - Function onehot(idx, n).
- Sub-module rr_pick: combinational. Inputs req, ptr; outputs found and idx. Instantiated once in the arbiter.
- The state register, hold counter and storage bank stay in dff_bank_arbiter.

Test Plan:
- Reset: assert rst mid-cycle with a clock running, period 4 -> Q=8'h00, Qb=8'hFF and gnt=0 immediately, without waiting for a clock edge.
- Single request:
  - Stimulus: req=4'b0010, wdata[1]=8'hA5.
  - Response: after 1 edge gnt=0010, Q=A5, Qb=5A, busy=1, owner=1.
  - Then drop req: next edge gnt=0, Q stays A5.
- Hold budget:
  - Stimulus: req[0] held high, wdata[0] incrementing 1,2,3,4,5 per cycle, MAX_HOLD=4.
  - Response: Q=1,2,3,4 across 4 granted cycles; then gnt=0 for 1 cycle; re-grant to 0 with Q=6.
- Round robin: req=4'b1111 held -> grant order 0,1,2,3,0, each lasting 4 cycles plus 1 bubble. This confirms wrap from 3 to 0.
- No preemption: owner 2 active, raise req[0] -> gnt stays 0100 until release; then 0 wins (ptr=3, wraps to 0).
- Fixed-priority build: with DFF_ARB_FIXED_PRIORITY_EN defined, req=4'b1010 held -> every grant goes to requester 1, and requester 3 never wins.
